// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop
// serializer with a registered line output and back-to-back frame support.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       write_d,
   input  logic [7:0] data_in,
   input  logic       data_length,
   input  logic       parity_en,
   input  logic       parity_odd,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       tx
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            len8_q, len8_d;
   logic            pen_q, pen_d;
   logic            par_q, par_d;

   logic [7:0]      thr_data_q, thr_data_d;
   logic            thr_len8_q, thr_len8_d;
   logic            thr_pen_q, thr_pen_d;
   logic            thr_podd_q, thr_podd_d;
   logic            thr_full_q, thr_full_d;

   logic            tx_q, tx_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            ready_q, ready_d;

   logic            wr_acc;
   logic            bit_end;
   logic            load;
   logic [2:0]      last_idx;
   logic            thr_par;

   assign wr_acc   = write_d & ready_q;
   assign bit_end  = (cnt_q == CNT_LAST);
   assign last_idx = len8_q ? 3'd7 : 3'd6;
   // Bit 7 is masked out of the parity in 7-bit mode.
   assign thr_par  = (^(thr_data_q & {thr_len8_q, 7'h7f})) ^ thr_podd_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      shift_d    = shift_q;
      len8_d     = len8_q;
      pen_d      = pen_q;
      par_d      = par_q;
      thr_data_d = thr_data_q;
      thr_len8_d = thr_len8_q;
      thr_pen_d  = thr_pen_q;
      thr_podd_d = thr_podd_q;
      thr_full_d = thr_full_q;
      load       = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (thr_full_q) begin
               load    = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = 3'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == last_idx) begin
                  state_d = pen_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (thr_full_q) begin
                  load    = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end

      if (load) begin
         shift_d    = thr_data_q;
         len8_d     = thr_len8_q;
         pen_d      = thr_pen_q;
         par_d      = thr_par;
         thr_full_d = 1'b0;
      end

      // Never coincides with load: a full THR holds ready low.
      if (wr_acc) begin
         thr_data_d = data_in;
         thr_len8_d = data_length;
         thr_pen_d  = parity_en;
         thr_podd_d = parity_odd;
         thr_full_d = 1'b1;
      end
   end

   always_comb begin
      tx_d = 1'b1;
      unique case (1'b1)
         (state_d == START):  tx_d = 1'b0;
         (state_d == DATA):   tx_d = shift_d[0];
         (state_d == PARITY): tx_d = par_d;
         default:             tx_d = 1'b1;
      endcase
      done_d  = (state_d == STOP) && (cnt_d == CNT_LAST);
      busy_d  = (state_d != IDLE);
      ready_d = ~thr_full_d;
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         shift_q    <= 8'h00;
         len8_q     <= 1'b0;
         pen_q      <= 1'b0;
         par_q      <= 1'b0;
         thr_data_q <= 8'h00;
         thr_len8_q <= 1'b0;
         thr_pen_q  <= 1'b0;
         thr_podd_q <= 1'b0;
         thr_full_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         len8_q     <= len8_d;
         pen_q      <= pen_d;
         par_q      <= par_d;
         thr_data_q <= thr_data_d;
         thr_len8_q <= thr_len8_d;
         thr_pen_q  <= thr_pen_d;
         thr_podd_q <= thr_podd_d;
         thr_full_q <= thr_full_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
      end
   end

   assign tx    = tx_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line recording compared against frames
// built from the framing rules (start, data LSB first, parity, stop).
module tb_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       write_d = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_length = 1'b1;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       ready, busy, done, tx;

   int checks = 0;
   int errors = 0;

   bit   rec = 1'b0;
   logic rtx[$], rdone[$], rbusy[$], rready[$];
   logic etx[$], edone[$], ebusy[$];
   int   eready[$];

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .arst_n(arst_n),
      .write_d(write_d),
      .data_in(data_in),
      .data_length(data_length),
      .parity_en(parity_en),
      .parity_odd(parity_odd),
      .ready(ready),
      .busy(busy),
      .done(done),
      .tx(tx)
   );

   always @(posedge clk) begin
      #1;
      if (rec) begin
         rtx.push_back(tx);
         rdone.push_back(done);
         rbusy.push_back(busy);
         rready.push_back(ready);
      end
   end

   function automatic void clear_all();
      rtx.delete(); rdone.delete(); rbusy.delete(); rready.delete();
      etx.delete(); edone.delete(); ebusy.delete(); eready.delete();
   endfunction

   function automatic void exp_idle(int n);
      for (int i = 0; i < n; i++) begin
         etx.push_back(1'b1);
         edone.push_back(1'b0);
         ebusy.push_back(1'b0);
         eready.push_back(2);
      end
   endfunction

   function automatic void exp_frame(bit [7:0] d, bit len8, bit pen, bit podd);
      bit bits[$];
      int nb;
      int ones;
      nb = len8 ? 8 : 7;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pen) bits.push_back(((ones % 2) == 1) ^ podd);
      bits.push_back(1'b1);
      for (int b = 0; b < bits.size(); b++) begin
         for (int c = 0; c < CPB; c++) begin
            etx.push_back(bits[b]);
            edone.push_back((b == bits.size() - 1) && (c == CPB - 1));
            ebusy.push_back(1'b1);
            eready.push_back(2);
         end
      end
   endfunction

   task automatic send_frame(string name, bit [7:0] d, bit len8, bit pen, bit podd);
      int total;
      @(negedge clk);
      clear_all();
      exp_idle(1);
      exp_frame(d, len8, pen, podd);
      exp_idle(3);
      eready[0] = 0;
      eready[1] = 1;
      eready[etx.size() - 1] = 1;
      total = etx.size();
      rec = 1'b1;
      write_d = 1'b1;
      data_in = d;
      data_length = len8;
      parity_en = pen;
      parity_odd = podd;
      @(negedge clk);
      write_d = 1'b0;
      data_in = 8'($urandom);
      repeat (total) @(negedge clk);
      rec = 1'b0;
      checks++;
      if (rtx.size() < total) begin
         errors++;
         $display("FAIL %s samples got %0d need %0d", name, rtx.size(), total);
      end
      for (int i = 0; i < total && i < rtx.size(); i++) begin
         checks++;
         if (rtx[i] !== etx[i]) begin
            errors++;
            $display("FAIL %s tx[%0d] got %b exp %b", name, i, rtx[i], etx[i]);
         end
         checks++;
         if (rdone[i] !== edone[i]) begin
            errors++;
            $display("FAIL %s done[%0d] got %b exp %b", name, i, rdone[i], edone[i]);
         end
         checks++;
         if (rbusy[i] !== ebusy[i]) begin
            errors++;
            $display("FAIL %s busy[%0d] got %b exp %b", name, i, rbusy[i], ebusy[i]);
         end
         if (eready[i] != 2) begin
            checks++;
            if (rready[i] !== 1'(eready[i])) begin
               errors++;
               $display("FAIL %s ready[%0d] got %b exp %0d", name, i, rready[i], eready[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      write_d = 1'b1;
      data_in = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx, ready, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL reset outs got %b exp 1100", {tx, ready, busy, done});
      end
      arst_n = 1'b1;
      write_d = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx, ready, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_idle outs got %b exp 1100", {tx, ready, busy, done});
      end
   endtask

   task automatic test_frames();
      send_frame("8n1_55", 8'h55, 1'b1, 1'b0, 1'b0);
      send_frame("7e1_c1", 8'hC1, 1'b0, 1'b1, 1'b0);
      send_frame("7o1_41", 8'h41, 1'b0, 1'b1, 1'b1);
      send_frame("8o1_ff", 8'hFF, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         send_frame("rand", 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      int total;
      int ndone;
      @(negedge clk);
      clear_all();
      exp_idle(1);
      exp_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      exp_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      exp_idle(3);
      total = etx.size();
      rec = 1'b1;
      write_d = 1'b1;
      data_in = 8'hA5;
      data_length = 1'b1;
      parity_en = 1'b0;
      parity_odd = 1'b0;
      @(negedge clk);
      write_d = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b ready_in_data got %b exp 1", ready);
      end
      write_d = 1'b1;
      data_in = 8'h3C;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b ready_full got %b exp 0", ready);
      end
      data_in = 8'h77;
      @(negedge clk);
      write_d = 1'b0;
      repeat (total) @(negedge clk);
      rec = 1'b0;
      ndone = 0;
      for (int i = 0; i < rdone.size(); i++) ndone += int'(rdone[i] === 1'b1);
      checks++;
      if (ndone != 2) begin
         errors++;
         $display("FAIL b2b done_count got %0d exp 2", ndone);
      end
      for (int i = 0; i < total && i < rtx.size(); i++) begin
         checks++;
         if (rtx[i] !== etx[i]) begin
            errors++;
            $display("FAIL b2b tx[%0d] got %b exp %b", i, rtx[i], etx[i]);
         end
         checks++;
         if (rbusy[i] !== ebusy[i]) begin
            errors++;
            $display("FAIL b2b busy[%0d] got %b exp %b", i, rbusy[i], ebusy[i]);
         end
      end
   endtask

   task automatic test_collision();
      bit [7:0] b[3];
      int give;
      int total;
      for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
      @(negedge clk);
      clear_all();
      exp_idle(1);
      for (int i = 0; i < 3; i++) exp_frame(b[i], 1'b0, 1'b1, 1'b1);
      exp_idle(3);
      total = etx.size();
      rec = 1'b1;
      data_length = 1'b0;
      parity_en = 1'b1;
      parity_odd = 1'b1;
      write_d = 1'b1;
      data_in = b[0];
      give = 1;
      for (int c = 0; c < 600 && write_d; c++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            if (give < 3) begin
               data_in = b[give];
               give++;
            end else begin
               write_d = 1'b0;
            end
         end
      end
      checks++;
      if (write_d !== 1'b0) begin
         errors++;
         $display("FAIL collision timeout accepted %0d exp 3", give);
         write_d = 1'b0;
      end
      for (int c = 0; c < 600 && rtx.size() < total; c++) @(negedge clk);
      rec = 1'b0;
      checks++;
      if (rtx.size() < total) begin
         errors++;
         $display("FAIL collision samples got %0d need %0d", rtx.size(), total);
      end
      for (int i = 0; i < total && i < rtx.size(); i++) begin
         checks++;
         if (rtx[i] !== etx[i]) begin
            errors++;
            $display("FAIL collision tx[%0d] got %b exp %b", i, rtx[i], etx[i]);
         end
         checks++;
         if (rdone[i] !== edone[i]) begin
            errors++;
            $display("FAIL collision done[%0d] got %b exp %b", i, rdone[i], edone[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      bit [7:0] d;
      int ndone;
      d = 8'($urandom);
      @(negedge clk);
      clear_all();
      rec = 1'b1;
      write_d = 1'b1;
      data_in = d;
      data_length = 1'b1;
      parity_en = 1'b0;
      @(negedge clk);
      write_d = 1'b0;
      repeat (17) @(negedge clk);
      checks++;
      if ({busy, tx} !== {1'b1, d[3]}) begin
         errors++;
         $display("FAIL rstmid bit3 got %b exp %b", {busy, tx}, {1'b1, d[3]});
      end
      arst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({tx, ready, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL rstmid outs got %b exp 1100", {tx, ready, busy, done});
      end
      write_d = 1'b1;
      data_in = 8'hFF;
      @(negedge clk);
      arst_n = 1'b1;
      write_d = 1'b0;
      repeat (12) @(negedge clk);
      rec = 1'b0;
      checks++;
      if ({tx, ready, busy} !== 3'b110) begin
         errors++;
         $display("FAIL rstmid idle got %b exp 110", {tx, ready, busy});
      end
      ndone = 0;
      for (int i = 0; i < rdone.size(); i++) ndone += int'(rdone[i] !== 1'b0);
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL rstmid done_pulses got %0d exp 0", ndone);
      end
      send_frame("post_rst_0f", 8'h0F, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_frames();
      test_back_to_back();
      test_collision();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
